// File: rtl/kv_wb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : kv_wb_initiator
// Brief    : Wishbone classic initiator turning key/value put/get commands
//            into single-beat bus cycles, with a bounded wait on ACK that
//            converts hung cycles into error responses.
// Revision : 1.0 - initial release
// ============================================================================
module kv_wb_initiator #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          TIMEOUT   = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  // command / response side
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [7:0]  cmd_key,
  input  logic [7:0]  cmd_value,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  err_count,
  // Wishbone initiator side
  output logic        CYC_o,
  output logic        STB_o,
  output logic        WE_o,
  output logic [3:0]  SEL_o,
  output logic [31:0] ADR_o,
  output logic [31:0] DAT_o,
  input  logic [31:0] DAT_i,
  input  logic        ACK_i
);

  // Last wait count value at which a missing ACK aborts the cycle.
  localparam logic [7:0] C_LAST_WAIT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        live_q, live_d;      // low until the first edge after reset release
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        end_cycle;

  // Only the low byte of read data is meaningful to the store.
  logic        unused_dat_hi;
  assign unused_dat_hi = ^DAT_i[31:8];

  // Ready and busy are decoded straight from the state register.
  assign cmd_ready = (state_q == S_IDLE) && live_q;
  assign busy      = (state_q == S_REQ) || (state_q == S_RESP);

  assign CYC_o     = cyc_q;
  assign STB_o     = cyc_q;
  assign WE_o      = we_q;
  assign SEL_o     = sel_q;
  assign ADR_o     = adr_q;
  assign DAT_o     = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign err_count = err_count_q;

  // Next-state and next-output computation for the command FSM.
  always_comb begin
    state_d     = state_q;
    live_d      = 1'b1;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    err_count_d = err_count_q;
    end_cycle   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d    = S_REQ;
          cyc_d      = 1'b1;
          we_d       = cmd_we;
          sel_d      = 4'b0001;
          adr_d      = BASE_ADDR + {22'b0, cmd_key, 2'b00};
          dat_d      = cmd_we ? {24'b0, cmd_value} : 32'b0;
          wait_cnt_d = 8'd0;
        end
      end
      S_REQ: begin
        // ACK takes priority even in the last allowed cycle.
        if (ACK_i) begin
          end_cycle  = 1'b1;
          rsp_data_d = we_q ? 8'h00 : DAT_i[7:0];
          rsp_err_d  = 1'b0;
        end else if (wait_cnt_q == C_LAST_WAIT) begin
          end_cycle  = 1'b1;
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b1;
          if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Closing the bus cycle returns every bus output to zero.
    if (end_cycle) begin
      state_d     = S_RESP;
      rsp_valid_d = 1'b1;
      cyc_d       = 1'b0;
      we_d        = 1'b0;
      sel_d       = 4'b0000;
      adr_d       = 32'b0;
      dat_d       = 32'b0;
    end
  end

  // State and output registers; reset clears the bus cycle immediately.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      live_q      <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'b0000;
      adr_q       <= 32'b0;
      dat_q       <= 32'b0;
      wait_cnt_q  <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      live_q      <= live_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      err_count_q <= err_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kv_wb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_kv_wb_initiator
// Brief    : Self-checking bench for kv_wb_initiator; a transaction-level
//            model predicts every output on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kv_wb_initiator;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          TO   = 16;

  logic        sys_clk, sys_rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [7:0]  cmd_key, cmd_value;
  logic        rsp_valid, rsp_err, busy;
  logic [7:0]  rsp_data, err_count;
  logic        CYC_o, STB_o, WE_o, ACK_i;
  logic [3:0]  SEL_o;
  logic [31:0] ADR_o, DAT_o, DAT_i;

  kv_wb_initiator #(.BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_key(cmd_key), .cmd_value(cmd_value),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .err_count(err_count),
    .CYC_o(CYC_o), .STB_o(STB_o), .WE_o(WE_o), .SEL_o(SEL_o),
    .ADR_o(ADR_o), .DAT_o(DAT_o), .DAT_i(DAT_i), .ACK_i(ACK_i)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model expectations
  logic        exp_cyc, exp_we, exp_rsp_valid, exp_rsp_err, exp_ready, exp_busy;
  logic [3:0]  exp_sel;
  logic [31:0] exp_adr, exp_dat;
  logic [7:0]  exp_rsp_data;
  int          exp_err_count;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, " CYC_o"},     32'(CYC_o),     32'(exp_cyc));
    chk({ph, " STB_o"},     32'(STB_o),     32'(exp_cyc));
    chk({ph, " WE_o"},      32'(WE_o),      32'(exp_we));
    chk({ph, " SEL_o"},     32'(SEL_o),     32'(exp_sel));
    chk({ph, " ADR_o"},     ADR_o,          exp_adr);
    chk({ph, " DAT_o"},     DAT_o,          exp_dat);
    chk({ph, " rsp_valid"}, 32'(rsp_valid), 32'(exp_rsp_valid));
    chk({ph, " rsp_data"},  32'(rsp_data),  32'(exp_rsp_data));
    chk({ph, " rsp_err"},   32'(rsp_err),   32'(exp_rsp_err));
    chk({ph, " err_count"}, 32'(err_count), 32'(exp_err_count));
    chk({ph, " cmd_ready"}, 32'(cmd_ready), 32'(exp_ready));
    chk({ph, " busy"},      32'(busy),      32'(exp_busy));
  endtask

  task automatic set_bus_idle();
    exp_cyc = 1'b0; exp_we = 1'b0; exp_sel = 4'h0; exp_adr = 32'h0; exp_dat = 32'h0;
  endtask

  task automatic set_idle_exp();
    set_bus_idle();
    exp_rsp_valid = 1'b0; exp_ready = 1'b1; exp_busy = 1'b0;
  endtask

  task automatic set_reset_exp();
    set_bus_idle();
    exp_rsp_valid = 1'b0; exp_ready = 1'b0; exp_busy = 1'b0;
    exp_rsp_data = 8'h00; exp_rsp_err = 1'b0; exp_err_count = 0;
  endtask

  // Idle cycles, optionally with stray ACK pulses that must be ignored.
  task automatic idle_cycles(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      set_idle_exp();
      check_all("idle");
      cmd_valid = 1'b0;
      cmd_key   = 8'($urandom);
      ACK_i     = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      DAT_i     = $urandom;
    end
  endtask

  // One command; delay = number of wait cycles before ACK (>= TO: never ACKs).
  task automatic do_txn(input bit we, input logic [7:0] key, input logic [7:0] val,
                        input int delay, input logic [31:0] rdata, input bit lit_en,
                        input logic [31:0] lit_adr, input logic [31:0] lit_dat,
                        input logic [7:0] lit_data);
    int  nreq;
    bit  acked;
    @(negedge sys_clk);
    set_idle_exp();
    check_all("pre");
    cmd_valid = 1'b1; cmd_we = we; cmd_key = key; cmd_value = val;
    ACK_i = 1'($urandom_range(0, 1));
    DAT_i = $urandom;

    acked = (delay < TO);
    nreq  = acked ? delay + 1 : TO;
    exp_cyc = 1'b1; exp_we = we; exp_sel = 4'b0001;
    exp_adr = BASE + 32'(key) * 4;
    exp_dat = we ? 32'(val) : 32'h0;
    exp_ready = 1'b0; exp_busy = 1'b1; exp_rsp_valid = 1'b0;

    for (int i = 0; i < nreq; i++) begin
      @(negedge sys_clk);
      check_all("req");
      if (lit_en && i == 0) begin
        chk("literal ADR_o", ADR_o, lit_adr);
        chk("literal DAT_o", DAT_o, lit_dat);
      end
      // Commands offered while busy must have no effect.
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_we    = 1'($urandom);
      cmd_key   = 8'($urandom);
      cmd_value = 8'($urandom);
      ACK_i     = (i == delay);
      DAT_i     = (i == delay) ? rdata : $urandom;
    end

    if (acked) begin
      exp_rsp_err  = 1'b0;
      exp_rsp_data = we ? 8'h00 : rdata[7:0];
    end else begin
      exp_rsp_err  = 1'b1;
      exp_rsp_data = 8'h00;
      exp_err_count = (exp_err_count >= 255) ? 255 : exp_err_count + 1;
    end
    set_bus_idle();
    exp_rsp_valid = 1'b1; exp_ready = 1'b0; exp_busy = 1'b1;
    @(negedge sys_clk);
    check_all("resp");
    if (lit_en) chk("literal rsp_data", 32'(rsp_data), 32'(lit_data));
    ACK_i     = 1'($urandom_range(0, 1));
    cmd_valid = 1'($urandom_range(0, 1));
    DAT_i     = $urandom;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_key = 8'h00; cmd_value = 8'h00;
    ACK_i = 1'b0; DAT_i = 32'h0;
    set_reset_exp();

    // Reset state
    @(negedge sys_clk);
    check_all("reset");
    @(negedge sys_clk);
    check_all("reset");
    sys_rst_n = 1'b1;

    // Ready one cycle after release, err_count zero
    @(negedge sys_clk);
    set_idle_exp();
    check_all("post-reset");
    chk("literal ready after release", 32'(cmd_ready), 32'd1);

    // Put key 05 value A7, ACK in first cycle
    do_txn(1'b1, 8'h05, 8'hA7, 0, 32'hDEAD_BEEF, 1'b1, 32'h3000_0014, 32'h0000_00A7, 8'h00);
    // Get key FF, three wait cycles, read 12345642
    do_txn(1'b0, 8'hFF, 8'h00, 3, 32'h1234_5642, 1'b1, 32'h3000_03FC, 32'h0, 8'h42);
    // Get with no ACK -> timeout
    do_txn(1'b0, 8'h10, 8'h00, 99, 32'h0, 1'b0, 32'h0, 32'h0, 8'h00);
    chk("literal err_count after one timeout", 32'(err_count), 32'd1);
    // ACK in the 16th STB cycle wins
    do_txn(1'b0, 8'h22, 8'h00, TO - 1, 32'h0000_0077, 1'b0, 32'h0, 32'h0, 8'h00);
    chk("literal rsp_err late ack", 32'(rsp_err), 32'd0);
    chk("literal rsp_data late ack", 32'(rsp_data), 32'h77);
    // Stray ACKs while idle
    idle_cycles(5, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      do_txn(1'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 20),
             $urandom, 1'b0, 32'h0, 32'h0, 8'h00);
      idle_cycles($urandom_range(0, 2), 1'b1);
    end

    // Saturation of the timeout counter
    for (int n = 0; n < 300; n++) begin
      do_txn(1'($urandom), 8'($urandom), 8'($urandom), TO + 5, 32'h0, 1'b0, 32'h0, 32'h0, 8'h00);
    end
    chk("literal err_count saturated", 32'(err_count), 32'd255);

    // Reset in the second REQ cycle
    @(negedge sys_clk);
    set_idle_exp();
    check_all("pre-rst");
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_key = 8'h33; ACK_i = 1'b0;
    exp_cyc = 1'b1; exp_we = 1'b0; exp_sel = 4'b0001; exp_adr = BASE + 32'h33 * 4;
    exp_dat = 32'h0; exp_ready = 1'b0; exp_busy = 1'b1;
    @(negedge sys_clk);
    check_all("rst req1");
    cmd_valid = 1'b0;
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    set_reset_exp();
    check_all("mid-reset");
    for (int i = 0; i < 2; i++) begin
      @(negedge sys_clk);
      check_all("in-reset");
      ACK_i = 1'($urandom_range(0, 1));
    end
    ACK_i = 1'b0;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    set_idle_exp();
    check_all("after mid-reset");
    // New put completes normally
    do_txn(1'b1, 8'h01, 8'h5A, 1, 32'h0, 1'b1, 32'h3000_0004, 32'h0000_005A, 8'h00);
    idle_cycles(2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kv_wb_initiator.md
# kv_wb_initiator

Wishbone classic initiator that issues key/value put and get transactions toward the key/value store's Wishbone responder port. It sits between a simple command/response interface (driven from IO pins, LA bits, or a local sequencer) and the Wishbone bus. It converts each accepted command into one single-beat bus cycle. A bounded wait on ACK turns hung cycles into error responses.

## Interface
- BASE_ADDR, 32'h3000_0000: byte address of key 0; key k maps to BASE_ADDR + 4*k.
- TIMEOUT, 16: number of cycles STB may stay high without ACK before abort; legal range 1..255.

Ports:
- sys_clk  in  1  single clock; all logic on rising edge.
- sys_rst_n  in  1  reset, asynchronous assert, active-low. Clears all state and outputs immediately.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; handshake = cmd_valid & cmd_ready.
- cmd_we  in  1  1 = put (write), 0 = get (read).
- cmd_key  in  8  key index.
- cmd_value  in  8  value for put; ignored for get.
- rsp_valid  out  1  one-cycle pulse per completed command.
- rsp_data  out  8  read value on get; 0 on put or error; holds until next rsp_valid.
- rsp_err  out  1  1 = timed out; holds until next rsp_valid.
- busy  out  1  high in REQ and RESP.
- err_count  out  8  saturating count of timeouts since reset.
- CYC_o, STB_o  out  1  Wishbone cycle and strobe; always equal to each other.
- WE_o  out  1  write enable.
- SEL_o  out  4  byte select; 4'b0001 for put and get.
- ADR_o  out  32  BASE_ADDR + {22'b0, cmd_key, 2'b00}.
- DAT_o  out  32  {24'b0, cmd_value} on put; 0 on get.
- DAT_i  in  32  read data; only [7:0] used.
- ACK_i  in  1  responder acknowledge.

## Operation
- States: IDLE, REQ, RESP.
- IDLE -> REQ on handshake. In that cycle, latch WE/ADR/DAT/SEL from the command and clear wait_cnt.
- REQ: CYC_o = STB_o = 1, and bus outputs stay stable.
  - ACK_i = 1 -> RESP. Capture rsp_data = DAT_i[7:0] if get, else 0, and set rsp_err = 0.
  - ACK_i = 0 and wait_cnt == TIMEOUT-1 -> RESP. Set rsp_err = 1, rsp_data = 0, and increment err_count, saturating at 255.
  - Otherwise, increment wait_cnt.
- RESP: rsp_valid = 1 for exactly one cycle, then go to IDLE. cmd_ready = 0 in RESP.
- In IDLE, CYC_o, STB_o, WE_o, SEL_o, ADR_o and DAT_o are all 0.
- ACK_i outside REQ is ignored and changes no state.
- ACK_i in the last allowed cycle (wait_cnt == TIMEOUT-1): ACK wins and rsp_err = 0.
- cmd_valid during REQ or RESP: no effect. The command must be held until cmd_ready.
- Reset mid-transaction: CYC_o and STB_o drop asynchronously and no response is issued. After reset, the block is in IDLE.
- Reset values: cmd_ready = 0 while sys_rst_n is low and 1 from the first cycle after release. All other outputs are 0.
- wait_cnt is 8 bits wide.

## Timing
- All outputs are registered, except cmd_ready and busy, which are decoded directly from the state register.
- Handshake at edge T: CYC_o and STB_o are high from cycle T+1.
- ACK seen in cycle T+k (k ≥ 1): CYC_o and STB_o are low in T+k+1. rsp_valid is high in T+k+1, and cmd_ready returns high in T+k+2.
- Minimum command period: 3 cycles (ACK in the first REQ cycle).
- Timeout: STB_o is high for exactly TIMEOUT cycles. rsp_valid with rsp_err = 1 follows in the next cycle.
- The bus cycle is single-beat classic Wishbone: no bursts and no back-to-back STB without CYC dropping.

## Test plan
- Reset with sys_rst_n low, outputs sampled -> all 0. One cycle after release, cmd_ready = 1 and err_count = 0.
- Put key 8'h05 value 8'hA7 with the responder ACKing in the first cycle -> ADR_o = 32'h3000_0014, DAT_o = 32'h0000_00A7, WE_o = 1, SEL_o = 4'b0001. STB is high for 1 cycle, then rsp_valid = 1 with rsp_err = 0 and rsp_data = 0.
- Get key 8'hFF with the responder returning DAT_i = 32'h1234_5642 after 3 wait cycles -> ADR_o = 32'h3000_03FC, WE_o = 0. STB is high for 4 cycles, then rsp_data = 8'h42 and rsp_err = 0.
- Get with no ACK (TIMEOUT = 16) -> STB is high for exactly 16 cycles, then rsp_valid with rsp_err = 1 and rsp_data = 0, and err_count = 1. Repeating the timeout 300 times leaves err_count saturated at 255.
- ACK arriving in STB cycle 16 with TIMEOUT = 16 -> normal completion and rsp_err = 0. A stray ACK_i pulse while in IDLE -> no rsp_valid.
- sys_rst_n asserted in the second REQ cycle -> CYC_o and STB_o are low in the same cycle and no rsp_valid appears. A new put after release completes normally.
